cpu_controller: RTL and testbench
=================================

# cpu_controller

Sequencing controller that drives the existing 16-bit datapath (register file, shifter, ALU, A/B/C/status registers) as its control-side counterpart. It latches a 16-bit instruction, decodes it, and steps a Moore FSM that issues one datapath control word per cycle: register reads into A and B, ALU compute into C or status, then register-file write-back. It sits between instruction fetch/stimulus and the datapath and replaces hand-driven control sequences.

## Interface
Parameters:
- None; widths are fixed by the datapath: 16-bit data, 3-bit register index.

Ports:
- clk  in  1  rising-edge clock; one clock; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in WAIT
- load  in  1  load `in` into the instruction register (IR); honoured only in WAIT
- in  in  16  instruction word
- w  out  1  high only in WAIT
- err  out  1  illegal-instruction trap flag; see Configuration
- readnum, writenum  out  3  register-file read and write index
- write  out  1  register-file write enable
- vsel  out  1  1 = write-back from datapath_in, 0 = from C
- datapath_in  out  16  sign-extended imm8
- loada, loadb, loadc, loads  out  1  datapath register enables
- asel, bsel  out  1  asel=1 forces A operand to 0; bsel always 0
- shift  out  2  shifter op, from IR[4:3] (forced 00 for MOV imm)
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B

## Operation
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0], imm8 IR[7:0].
- Decoding: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}; everything else illegal.
- datapath_in = {{8{imm8[7]}}, imm8}, combinational from IR.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, CALC, WRITE_REG, TRAP (TRAP exists only with the macro).
- WAIT: w=1; on s=1 go to DECODE. A simultaneous load and s loads IR and starts on the new value.
- DECODE: no enables; go to WRITE_IMM (MOV imm), GET_B (MOV reg, MVN), GET_A (ADD, CMP, AND), or illegal handling.
- WRITE_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> CALC.
- CALC: shift=sh, ALUop = op for 101 and 00 for MOV reg; asel=1 for MOV reg; loads=1 for CMP, otherwise loadc=1. CMP -> WAIT, others -> WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
- Enables not listed for a state are 0. readnum and writenum are 0 when unused.
- Outputs are Moore decodes of state and IR, with no combinational path from s or load.

## Timing
- Reset value: state WAIT, IR=0, w=1, err=0, and all enables, readnum, writenum, shift, ALUop, vsel, asel and bsel at 0.
- Reset asserted mid-instruction aborts it immediately, and no further write occurs.
- Cycles from s sampled to back in WAIT: MOV imm 3, CMP 5, MOV reg/MVN 5, ADD/AND 6.
- Each enable is high for exactly one cycle, and the datapath captures on the following edge.
- s and load are ignored outside WAIT, so IR is stable for the whole instruction.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode moves from DECODE to TRAP. TRAP holds err=1 and w=0 with no enables, and only reset leaves it.
- Not defined: an illegal opcode moves from DECODE to WAIT with no enables, and err is tied to 0.

## Structure
- Package cpu_ctrl_pkg contains the state enum, opcode/op constants, the ALUop encodings (ADD/SUB/AND/MVN), and the shift encodings.
- Sub-module instr_dec is purely combinational. It takes IR and produces the fields, sximm8, an instruction-class enum and an illegal flag.
- The FSM and IR live in cpu_controller.

## Test plan
- Reset, then in=16'hD007 (MOV R0,#7) with load, then s: w drops for 3 cycles, one write with writenum=0, vsel=1, datapath_in=7.
- in=16'hD080 (MOV R0,#-128): datapath_in=16'hFF80.
- ADD R2,R1,R0,LSL#1 (16'hA148): the enable sequence is loada (readnum=1), then loadb (readnum=0), then loadc with shift=01 and ALUop=00, then write with writenum=2. The paired datapath yields R2=16 for R0=7, R1=2.
- CMP R3,R1,LSR#1 (16'hAB11): loads=1 with ALUop=01, no write, and w returns after 5 cycles.
- Pulse load and s mid-ADD: IR is unchanged and the sequence completes identically. Deassert rst_n mid-CALC: w=1 immediately and write is never asserted.
- in=16'hE000 (illegal): with CTRL_ILLEGAL_TRAP_EN, err=1 persists until reset. Without it, the controller returns to WAIT in 2 cycles with err=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared types and encodings for the cpu_controller slice: FSM
//            state enum, instruction-class enum, opcode/op field values,
//            ALU and shifter operation encodings, and the imm8 sign-extender.
// Ports    : none (package)
// Config   : CTRL_ILLEGAL_TRAP_EN selects whether ST_TRAP is reachable
//            (the encoding is always reserved here).
// Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_CALC      = 3'd5,
    ST_WRITE_REG = 3'd6,
    ST_TRAP      = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    IC_MOV_IMM = 3'd0,
    IC_MOV_REG = 3'd1,
    IC_ADD     = 3'd2,
    IC_CMP     = 3'd3,
    IC_AND     = 3'd4,
    IC_MVN     = 3'd5,
    IC_ILLEGAL = 3'd6
  } iclass_e;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALUop encodings (the ALU-class op field maps onto these 1:1)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Shifter encodings
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_dec.sv
`default_nettype none
// ============================================================================
// Module   : instr_dec
// Purpose  : Purely combinational instruction decoder. Splits the latched IR
//            into its register/shift fields, sign-extends imm8 and classifies
//            the instruction.
// Ports    : ir      in  16  latched instruction
//            op      out  2  IR[12:11]
//            rn      out  3  IR[10:8]
//            rd      out  3  IR[7:5]
//            sh      out  2  IR[4:3]
//            rm      out  3  IR[2:0]
//            sximm8  out 16  sign-extended IR[7:0]
//            iclass  out  3  instruction class
//            illegal out  1  opcode/op pair not recognised
// Revision : 1.0  initial release
// ============================================================================
module instr_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output iclass_e     iclass,
  output logic        illegal
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    iclass = IC_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      iclass = IC_MOV_IMM;
      else if (op == OP_MOV_REG) iclass = IC_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  iclass = IC_ADD;
        OP_CMP:  iclass = IC_CMP;
        OP_AND:  iclass = IC_AND;
        default: iclass = IC_MVN;
      endcase
    end
  end

  assign illegal = (iclass == IC_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Moore sequencing controller for the 16-bit datapath. Latches an
//            instruction while idle, decodes it and issues one datapath
//            control word per cycle (read A, read B, compute, write back).
// Ports    : clk, rst_n        clock, async active-low reset
//            s, load, in       start, IR load, instruction word (WAIT only)
//            w, err            idle flag, illegal-instruction trap flag
//            readnum/writenum  register-file indices
//            write, vsel       write enable, write-back source select
//            datapath_in       sign-extended imm8
//            loada/b/c/s       datapath register enables
//            asel, bsel        operand selects
//            shift, ALUop      shifter and ALU operations
// Config   : `define CTRL_ILLEGAL_TRAP_EN to park in TRAP (err=1) on an
//            illegal instruction; otherwise it is dropped back to WAIT.
// Revision : 1.0  initial release
// ============================================================================
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic [15:0] datapath_in,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [1:0]  dec_op;
  logic [2:0]  dec_rn, dec_rd, dec_rm;
  logic [1:0]  dec_sh;
  logic [15:0] dec_sximm8;
  iclass_e     dec_iclass;
  logic        dec_illegal;

  instr_dec u_instr_dec (
    .ir      (ir_q),
    .op      (dec_op),
    .rn      (dec_rn),
    .rd      (dec_rd),
    .sh      (dec_sh),
    .rm      (dec_rm),
    .sximm8  (dec_sximm8),
    .iclass  (dec_iclass),
    .illegal (dec_illegal)
  );

  // IR only accepts new words while idle so it is frozen for a whole
  // instruction; load with s in the same cycle starts on the new word.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_WAIT && load) ir_d = in;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (s) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_WAIT;
`endif
        end else begin
          case (dec_iclass)
            IC_MOV_IMM:        state_d = ST_WRITE_IMM;
            IC_MOV_REG, IC_MVN: state_d = ST_GET_B;
            default:           state_d = ST_GET_A;
          endcase
        end
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_CALC;
      ST_CALC:      state_d = (dec_iclass == IC_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:      state_d = ST_TRAP;
`endif
      default:      state_d = ST_WAIT;
    endcase
  end

  // Moore outputs: depend only on state_q and ir_q
  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_WRITE_IMM: begin
        writenum = dec_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      ST_GET_A: begin
        readnum = dec_rn;
        loada   = 1'b1;
      end
      ST_GET_B: begin
        readnum = dec_rm;
        loadb   = 1'b1;
      end
      ST_CALC: begin
        shift = dec_sh;
        // MOV reg is computed as 0 + shifted B
        if (dec_iclass == IC_MOV_REG) begin
          ALUop = ALU_ADD;
          asel  = 1'b1;
        end else begin
          ALUop = dec_op;
        end
        if (dec_iclass == IC_CMP) loads = 1'b1;
        else                      loadc = 1'b1;
      end
      ST_WRITE_REG: begin
        writenum = dec_rd;
        write    = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bsel        = 1'b0;
  assign datapath_in = dec_sximm8;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Directed self-checking bench for cpu_controller, with a small
//            behavioural datapath (register file, shifter, ALU) driven by
//            the controller outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w, err, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [15:0] datapath_in;
  logic [1:0]  shift, alu_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .load        (load),
    .in          (instr),
    .w           (w),
    .err         (err),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .vsel        (vsel),
    .datapath_in (datapath_in),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (alu_op)
  );

  // ---------------- behavioural datapath ----------------
  logic [15:0] rf [8];
  logic [15:0] a_reg = 16'h0, b_reg = 16'h0, c_reg = 16'h0;
  logic [15:0] b_sh, a_in, alu_out;
  int          wr_total = 0;

  always_comb begin
    case (shift)
      2'b00:   b_sh = b_reg;
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      default: b_sh = {b_reg[15], b_reg[15:1]};
    endcase
    a_in = asel ? 16'h0 : a_reg;
    case (alu_op)
      2'b00:   alu_out = a_in + b_sh;
      2'b01:   alu_out = a_in - b_sh;
      2'b10:   alu_out = a_in & b_sh;
      default: alu_out = ~b_sh;
    endcase
  end

  always @(posedge clk) begin
    if (write) begin
      rf[writenum] <= vsel ? datapath_in : c_reg;
      wr_total     <= wr_total + 1;
    end
    if (loada) a_reg <= rf[readnum];
    if (loadb) b_reg <= rf[readnum];
    if (loadc) c_reg <= alu_out;
  end

  // ---------------- per-instruction trace ----------------
  // seq holds one hex digit per enable seen: A=1 B=2 C=3 S=4 W=5, F=overlap
  logic [31:0] seq;
  logic [2:0]  rd_a, rd_b, w_num;
  logic [1:0]  c_shift, c_alu;
  logic        c_asel, w_vsel, err_seen;
  logic [15:0] w_dpin;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    int n;
    logic [3:0] code;
    n = int'(loada) + int'(loadb) + int'(loadc) + int'(loads) + int'(write);
    code = 4'h0;
    if (loada) begin code = 4'h1; rd_a = readnum; end
    if (loadb) begin code = 4'h2; rd_b = readnum; end
    if (loadc) code = 4'h3;
    if (loads) code = 4'h4;
    if (loadc || loads) begin c_shift = shift; c_alu = alu_op; c_asel = asel; end
    if (write) begin code = 4'h5; w_num = writenum; w_vsel = vsel; w_dpin = datapath_in; end
    if (n > 1) code = 4'hF;
    if (n > 0) seq = {seq[27:0], code};
    if (err) err_seen = 1'b1;
  endtask

  // Load+start one instruction and run it back to WAIT. cyc counts clock
  // edges from the one that samples s up to the one that re-enters WAIT.
  // poke pulses load/s with a different word while the FSM is busy.
  task automatic exec(input logic [15:0] iw, input bit poke);
    seq = 32'h0; rd_a = 3'd0; rd_b = 3'd0; w_num = 3'd0; c_shift = 2'd0;
    c_alu = 2'd0; c_asel = 1'b0; w_vsel = 1'b0; w_dpin = 16'h0; err_seen = 1'b0;
    @(posedge clk); #1;
    instr = iw; load = 1'b1; s = 1'b1;
    @(negedge clk); sample();
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0; cyc = 1;
    while (w !== 1'b1 && cyc < 16) begin
      @(negedge clk); sample();
      if (poke && cyc == 2) begin instr = 16'hE000; load = 1'b1; s = 1'b1; end
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w", w, 1);
    chk("rst_err", err, 0);
    chk("rst_enables", {write, loada, loadb, loadc, loads}, 0);
    chk("rst_nums", {readnum, writenum}, 0);
    chk("rst_sel", {shift, alu_op, vsel, asel, bsel}, 0);
    chk("rst_ir", datapath_in, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // ---- MOV R0,#-128 ----
    exec(16'hD080, 0);
    chk("movneg_cyc", cyc, 3);
    chk("movneg_seq", seq, 32'h5);
    chk("movneg_dpin", w_dpin, 16'hFF80);
    chk("movneg_wnum", w_num, 0);

    // ---- MOV R0,#7 ----
    exec(16'hD007, 0);
    chk("mov7_cyc", cyc, 3);
    chk("mov7_seq", seq, 32'h5);
    chk("mov7_vsel", w_vsel, 1);
    chk("mov7_dpin", w_dpin, 16'h0007);
    chk("mov7_r0", rf[0], 16'h0007);

    // ---- MOV R1,#2 ----
    exec(16'hD102, 0);
    chk("mov2_wnum", w_num, 1);
    chk("mov2_r1", rf[1], 16'h0002);

    // ---- ADD R2,R1,R0,LSL#1 ----
    exec(16'hA148, 0);
    chk("add_cyc", cyc, 6);
    chk("add_seq", seq, 32'h1235);
    chk("add_rda", rd_a, 1);
    chk("add_rdb", rd_b, 0);
    chk("add_shift", c_shift, 2'b01);
    chk("add_alu", c_alu, 2'b00);
    chk("add_wnum", w_num, 2);
    chk("add_vsel", w_vsel, 0);
    chk("add_r2", rf[2], 16'd16);

    // ---- CMP R3,R1,LSR#1 ----
    exec(16'hAB11, 0);
    chk("cmp_cyc", cyc, 5);
    chk("cmp_seq", seq, 32'h124);
    chk("cmp_rd", {rd_a, rd_b}, {3'd3, 3'd1});
    chk("cmp_alu_sh", {c_alu, c_shift}, {2'b01, 2'b10});

    // ---- MVN R4,R1 ----
    exec(16'hB881, 0);
    chk("mvn_cyc", cyc, 5);
    chk("mvn_seq", seq, 32'h235);
    chk("mvn_alu", c_alu, 2'b11);
    chk("mvn_r4", rf[4], 16'hFFFD);

    // ---- MOV R5,R1,LSL#1 ----
    exec(16'hC0A9, 0);
    chk("movr_cyc", cyc, 5);
    chk("movr_ctl", {c_asel, c_alu, c_shift}, {1'b1, 2'b00, 2'b01});
    chk("movr_r5", rf[5], 16'h0004);

    // ---- AND R6,R0,R5 ----
    exec(16'hB0C5, 0);
    chk("and_cyc", cyc, 6);
    chk("and_alu", c_alu, 2'b10);
    chk("and_r6", rf[6], 16'h0004);

    // ---- load/s pulsed mid-ADD are ignored ----
    exec(16'hA148, 1);
    chk("poke_cyc", cyc, 6);
    chk("poke_seq", seq, 32'h1235);
    chk("poke_wnum", w_num, 2);
    chk("poke_ir", datapath_in, 16'h0048);
    chk("poke_r2", rf[2], 16'd16);
    chk("bsel", bsel, 0);

    // ---- reset during CALC of ADD R7,R1,R0,LSL#1 ----
    @(posedge clk); #1;
    instr = 16'hA1E8; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_calc", loadc, 1);
    begin
      int wr0;
      wr0 = wr_total;
      rst_n = 1'b0;
      #1;
      chk("abort_w", w, 1);
      chk("abort_en", {write, loadc}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_nowrite", wr_total, wr0);
      chk("abort_idle", w, 1);
    end

    // ---- illegal instruction ----
`ifdef CTRL_ILLEGAL_TRAP_EN
    @(posedge clk); #1;
    instr = 16'hE000; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("trap_err", err, 1);
    chk("trap_w", w, 0);
    chk("trap_en", {write, loada, loadb, loadc, loads}, 0);
    s = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s = 1'b0;
    chk("trap_hold", {err, w}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("trap_rst", {err, w}, 2'b01);
    @(negedge clk); rst_n = 1'b1;
`else
    exec(16'hE000, 0);
    chk("ill_cyc", cyc, 2);
    chk("ill_seq", seq, 0);
    chk("ill_err", err_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
